serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned/two's-complement subtractor that computes `a - b` one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow. It is the subtracting counterpart to the team's adder cells and is intended as the reference sequential arithmetic block for area-constrained datapaths. Operands are captured on a start handshake, and the result is presented with a one-cycle done pulse.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request to begin a subtraction; accepted only when `busy`=0.
- `a` in WIDTH: minuend; sampled only on the accepting edge.
- `b` in WIDTH: subtrahend; sampled only on the accepting edge.
- `busy` out 1: high while bits are being processed.
- `done` out 1: one-cycle pulse marking that `diff`/`bout`/`ovf` were just updated.
- `diff` out WIDTH: `(a - b) mod 2^WIDTH`.
- `bout` out 1: final borrow; equals 1 iff `a < b` unsigned.
- `ovf` out 1: signed overflow, i.e. `a[W-1] != b[W-1]` and `diff[W-1] != a[W-1]`.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE or DONE with `start`=1 → RUN. On that edge:
  - load the `a` and `b` shift registers;
  - clear the borrow register to 0;
  - clear the bit counter to 0;
  - clear the working shift register.
- IDLE with `start`=0 → IDLE.
- DONE with `start`=0 → IDLE.
- RUN, on each edge:
  - d = a0 ^ b0 ^ br;
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br);
  - shift d into the working register MSB-side, so the LSB lands at bit 0 after WIDTH shifts;
  - shift the operands right by 1;
  - increment the counter.
- RUN when counter = WIDTH-1 → DONE. On that same edge:
  - copy the completed working value into `diff`;
  - copy the final borrow into `bout`;
  - copy the computed signed overflow into `ovf`.
- `diff`, `bout` and `ovf` are output registers. They change only on the completion edge and hold until the next completion. Intermediate bits are never visible.
- `start` while in RUN is ignored: no queueing, no restart, no error flag.
- Reset (any state, including mid-RUN):
  - FSM → IDLE;
  - `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0;
  - internal registers cleared;
  - any in-flight operation is discarded.
- `rst` and `start` high on the same edge: reset wins.

## Timing
- `busy` = (state == RUN), registered-state decode. `done` = (state == DONE).
- Latency: with `start` accepted at edge 0, `busy` is high after edges 0..WIDTH-1. After edge WIDTH, `done`=1, `busy`=0 and the results are valid.
- Throughput: with `start` held high in DONE, a new operation is accepted on the edge that ends DONE. This gives one result every WIDTH+1 cycles.
- `done` is high for exactly one cycle per accepted operation. Back-to-back operations never merge pulses.
- The counter is ⌈log2(WIDTH)⌉ bits and never wraps in RUN, because it exits at WIDTH-1.

## Structure
- Shared package `adder_pkg`:
  - `state_t` enum (IDLE, RUN, DONE);
  - default width constant `ADDER_WIDTH_DEFAULT = 8`.
- Sub-module `full_subtractor`: purely combinational.
  - Inputs: `a`, `b`, `bin`.
  - Outputs: `d`, `bout`.
  - Instantiated once.
- The top level owns the FSM, counter, shift registers, borrow flop and output registers.

## Test plan
All cases use WIDTH=8.
- **Reset values:** assert `rst` 2 cycles → `busy`=0, `done`=0, `diff`=0x00, `bout`=0, `ovf`=0; after release, IDLE holds with `start`=0.
- **Basic subtractions:**
  - `a`=0x05, `b`=0x03, start at edge 0 → `busy` for 8 cycles, `done` after edge 8, `diff`=0x02, `bout`=0, `ovf`=0.
  - `a`=0x03, `b`=0x05 → `diff`=0xFE, `bout`=1, `ovf`=0.
  - `a`=0x80, `b`=0x01 → `diff`=0x7F, `bout`=0, `ovf`=1.
  - `a`=0x00, `b`=0xFF → `diff`=0x01, `bout`=1, `ovf`=0.
- **Start while busy:**
  - start 0x05−0x03;
  - pulse `start` with `a`=0xFF, `b`=0x00 at cycle 3 → ignored;
  - result is 0x02 at cycle 8, with a single `done` pulse.
- **Back-to-back:**
  - hold `start`=1 with new operands 0x10−0x01 during the DONE cycle → accepted;
  - next `done` arrives 9 cycles after the first, with `diff`=0x0F;
  - `diff` stays 0x02 until then.
- **Reset mid-RUN:**
  - assert `rst` at cycle 4 of an operation → next cycle: IDLE, all outputs 0;
  - no `done` follows;
  - a subsequent start runs normally.
- **Randomized sweep:** 1000 random operand pairs → `diff`, `bout`, `ovf` match the reference model.

Source files
------------

// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// Module : adder_pkg
// Brief  : Shared FSM state type and default width for the serial arithmetic cells.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADDER_WIDTH_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// Module : full_subtractor
// Brief  : Single-bit combinational full subtractor (a - b - bin).
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// Module : serial_subtractor
// Brief  : Bit-serial a - b, LSB first, one bit per clock with a registered borrow.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   work_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               br_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               ovf_q;

  logic               fs_d;
  logic               br_d;
  logic [WIDTH-1:0]   work_d;
  logic               ovf_d;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (br_d)
  );

  // New bit enters at the MSB so the first (LSB) bit reaches bit 0 after WIDTH shifts.
  assign work_d = (work_q >> 1) | {fs_d, {(WIDTH-1){1'b0}}};

  // On the final step a_q[0]/b_q[0] hold the original sign bits.
  assign ovf_d  = (a_q[0] != b_q[0]) && (fs_d != a_q[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            a_q     <= a;
            b_q     <= b;
            work_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_d;
          work_q <= work_d;
          if (cnt_q == C_LAST) begin
            state_q <= DONE;
            diff_q  <= work_d;
            bout_q  <= br_d;
            ovf_q   <= ovf_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// Module : tb_serial_subtractor
// Brief  : Scoreboard bench for serial_subtractor (WIDTH=8), directed plus random.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_done   = 0;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   sx, sy, r;
    sx   = x[W-1] ? int'(x) - 256 : int'(x);
    sy   = y[W-1] ? int'(y) - 256 : int'(y);
    r    = sx - sy;
    e.d  = W'((int'(x) - int'(y) + 256) % 256);
    e.bo = (int'(x) < int'(y));
    e.ov = (r < -128) || (r > 127);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_diff", 32'(diff), 32'(e.d));
        check("sb_bout", 32'(bout), 32'(e.bo));
        check("sb_ovf",  32'(ovf),  32'(e.ov));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) check("timeout_busy", 32'(busy), 32'd0);
  endtask

  // Issues an op from IDLE/DONE and checks the cycle-exact latency. Optionally
  // pulses an ignored start while busy. Leaves the bench 1 step after the done edge.
  task automatic run_timed(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] ed, input logic eb, input logic eo,
                           input bit inject);
    start = 1'b1; a = x; b = y;
    sb.push_back(model(x, y));
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) tick();
      check($sformatf("busy_e%0d", i), 32'(busy), 32'd1);
      if (inject && i == 2) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end
      if (inject && i == 3) start = 1'b0;
    end
    tick();
    check("done_at_w", 32'(done), 32'd1);
    check("busy_at_w", 32'(busy), 32'd0);
    check("diff_dir",  32'(diff), 32'(ed));
    check("bout_dir",  32'(bout), 32'(eb));
    check("ovf_dir",   32'(ovf),  32'(eo));
  endtask

  initial begin
    int d0;
    exp_t e;

    // Reset values
    rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst = 1'b0; start = 1'b0;
    tick(); tick(); tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Basic subtractions
    run_timed(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0); tick();
    run_timed(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0); tick();
    run_timed(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0); tick();
    run_timed(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0); tick();

    // Start while busy is ignored; exactly one done pulse
    d0 = n_done;
    run_timed(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    tick();
    check("ignored_done_cnt", 32'(n_done), 32'(d0 + 1));
    check("ignored_done_low", 32'(done), 32'd0);
    check("ignored_busy_low", 32'(busy), 32'd0);
    tick();

    // Back-to-back: accept in the DONE cycle
    run_timed(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    start = 1'b1; a = 8'h10; b = 8'h01;
    sb.push_back(model(8'h10, 8'h01));
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) tick();
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_hold", 32'(diff), 32'h02);
    end
    tick();
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_diff", 32'(diff), 32'h0F);
    tick();

    // Reset mid-RUN
    start = 1'b1; a = 8'h33; b = 8'h11;
    sb.push_back(model(8'h33, 8'h11));
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    sb.delete();
    d0 = n_done;
    tick();
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_diff", 32'(diff), 32'd0);
    check("mrst_bout", 32'(bout), 32'd0);
    check("mrst_ovf",  32'(ovf),  32'd0);
    rst = 1'b0;
    repeat (12) tick();
    check("mrst_no_done", 32'(n_done), 32'(d0));
    run_timed(8'h40, 8'h41, 8'hFF, 1'b1, 1'b0, 1'b0);
    tick();

    // Randomized sweep; ops issued whenever not busy (including during DONE)
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = W'($urandom);
      if (($urandom & 3) == 0) begin
        x = ($urandom & 1) ? 8'h80 : 8'h7F;
        y = ($urandom & 1) ? 8'hFF : 8'h00;
      end
      wait_not_busy();
      start = 1'b1; a = x; b = y;
      sb.push_back(model(x, y));
      tick();
      start = 1'b0;
      if (($urandom & 7) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
